// File: rtl/ov5640_cfg_ctrl.sv
// ov5640_cfg_ctrl
// Power-up sequencer and register-table scheduler for the OV5640 sensor.
// It walks pwdn/rst_n through the power-on timing, waits for the sensor to
// settle, then issues one SCCB write per ROM entry. An entry whose address is
// 16'hFFFF is a delay of (value * MS_CYC) cycles instead of a write.
// Optional build macro: OV5640_CFG_RETRY_EN. When defined, a NACKed write is
// re-issued up to MAX_RETRY times; an entry that still fails sets the sticky
// cfg_err and is skipped. When undefined, NACK is ignored and cfg_err is 0.
module ov5640_cfg_ctrl #(
    parameter int unsigned PWDN_CYC   = 100000,
    parameter int unsigned RST_CYC    = 50000,
    parameter int unsigned SETTLE_CYC = 1000000,
    parameter int unsigned MS_CYC     = 50000,
    parameter int unsigned REG_NUM    = 252,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        sclk_50m,
    input  logic        s_rst_n,
    input  logic        reinit,
    output logic [7:0]  cfg_idx,
    input  logic [23:0] cfg_data,
    output logic        wr_req,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_done,
    input  logic        wr_nack,
    output logic        ov5640_pwdn,
    output logic        ov5640_rst_n,
    output logic        cfg_done,
    output logic        cfg_err
);

    localparam logic [31:0] PWDN_LAST   = 32'(PWDN_CYC - 1);
    localparam logic [31:0] RST_LAST    = 32'(RST_CYC - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [7:0]  IDX_LAST    = 8'(REG_NUM - 1);

    typedef enum logic [3:0] {
        S_PWDN, S_RST, S_SETTLE, S_FETCH, S_REQ, S_DELAY, S_NEXT, S_DONE, S_RETRY
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  cfg_idx_q, cfg_idx_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [31:0] delay_tgt;

    // A delay entry carries its length in milliseconds in the data byte.
    assign delay_tgt = 32'(wr_data_q) * MS_CYC;

`ifdef OV5640_CFG_RETRY_EN
    localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);
    logic [7:0] retry_q, retry_d;
    logic       cfg_err_q, cfg_err_d;
`else
    logic unused_retry_inputs;
    assign unused_retry_inputs = ^{wr_nack, 8'(MAX_RETRY)};
`endif

    // State and datapath registers; reset is synchronous and active-low.
    always_ff @(posedge sclk_50m) begin
        if (!s_rst_n) begin
            state_q   <= S_PWDN;
            cnt_q     <= '0;
            cfg_idx_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef OV5640_CFG_RETRY_EN
            retry_q   <= '0;
            cfg_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_idx_q <= cfg_idx_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef OV5640_CFG_RETRY_EN
            retry_q   <= retry_d;
            cfg_err_q <= cfg_err_d;
`endif
        end
    end

    // Next-state and datapath update; reinit overrides everything, including wr_done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_idx_d = cfg_idx_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef OV5640_CFG_RETRY_EN
        retry_d   = retry_q;
        cfg_err_d = cfg_err_q;
`endif
        case (state_q)
            S_PWDN: begin
                if (cnt_q == PWDN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RST;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_FETCH: begin
                // First cycle covers ROM latency; the second latches the word.
                if (cnt_q == '0) begin
                    cnt_d = 32'd1;
                end else begin
                    cnt_d     = '0;
                    wr_addr_d = cfg_data[23:8];
                    wr_data_d = cfg_data[7:0];
`ifdef OV5640_CFG_RETRY_EN
                    retry_d   = '0;
`endif
                    state_d   = (cfg_data[23:8] == 16'hFFFF) ? S_DELAY : S_REQ;
                end
            end
            S_REQ: begin
                if (wr_done) begin
`ifdef OV5640_CFG_RETRY_EN
                    if (wr_nack) begin
                        if (retry_q == RETRY_MAX) begin
                            cfg_err_d = 1'b1;
                            state_d   = S_NEXT;
                        end else begin
                            retry_d = retry_q + 8'd1;
                            state_d = S_RETRY;
                        end
                    end else begin
                        state_d = S_NEXT;
                    end
`else
                    state_d = S_NEXT;
`endif
                end
            end
            S_RETRY: state_d = S_REQ;
            S_DELAY: begin
                if (delay_tgt == '0 || cnt_q == delay_tgt - 32'd1) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_NEXT: begin
                if (cfg_idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cfg_idx_d = cfg_idx_q + 8'd1;
                    state_d   = S_FETCH;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_PWDN;
        endcase

        if (reinit) begin
            state_d   = S_PWDN;
            cnt_d     = '0;
            cfg_idx_d = '0;
            wr_addr_d = '0;
            wr_data_d = '0;
`ifdef OV5640_CFG_RETRY_EN
            retry_d   = '0;
            cfg_err_d = 1'b0;
`endif
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        ov5640_pwdn  = 1'b0;
        ov5640_rst_n = 1'b1;
        wr_req       = 1'b0;
        cfg_done     = 1'b0;
        case (state_q)
            S_PWDN: begin
                ov5640_pwdn  = 1'b1;
                ov5640_rst_n = 1'b0;
            end
            S_RST:   ov5640_rst_n = 1'b0;
            S_REQ:   wr_req       = 1'b1;
            S_DONE:  cfg_done     = 1'b1;
            default: ;
        endcase
    end

    assign cfg_idx = cfg_idx_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
`ifdef OV5640_CFG_RETRY_EN
    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// tb_ov5640_cfg_ctrl
// Directed bench for ov5640_cfg_ctrl with shortened timing parameters and a
// four-entry ROM (write, 3 ms delay, write, write). Honours OV5640_CFG_RETRY_EN.
module tb_ov5640_cfg_ctrl;

    logic        clk = 1'b0;
    logic        s_rst_n;
    logic        reinit;
    logic [7:0]  cfg_idx;
    logic [23:0] cfg_data;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        wr_nack;
    logic        ov5640_pwdn;
    logic        ov5640_rst_n;
    logic        cfg_done;
    logic        cfg_err;

    logic [23:0] rom [0:3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Registered ROM: word for a new index is visible one cycle later.
    always @(posedge clk) cfg_data <= rom[cfg_idx[1:0]];

    ov5640_cfg_ctrl #(
        .PWDN_CYC  (10),
        .RST_CYC   (5),
        .SETTLE_CYC(20),
        .MS_CYC    (4),
        .REG_NUM   (4),
        .MAX_RETRY (3)
    ) dut (
        .sclk_50m    (clk),
        .s_rst_n     (s_rst_n),
        .reinit      (reinit),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .wr_nack     (wr_nack),
        .ov5640_pwdn (ov5640_pwdn),
        .ov5640_rst_n(ov5640_rst_n),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (wr_req !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, wr_req, 1);
    endtask

    // Act as the SCCB master for one write: answer 8 cycles after the request.
    task automatic serve(input string tag, input logic [15:0] a, input logic [7:0] d,
                         input logic nack);
        wait_req({tag, "_req"});
        chk({tag, "_addr"}, wr_addr, a);
        chk({tag, "_data"}, wr_data, d);
        step(7);
        chk({tag, "_hold"}, {wr_req, wr_addr, wr_data}, {1'b1, a, d});
        wr_done = 1'b1;
        wr_nack = nack;
        step(1);
        wr_done = 1'b0;
        wr_nack = 1'b0;
        chk({tag, "_drop"}, wr_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        rom[0] = 24'h300882;
        rom[1] = 24'hFFFF03;
        rom[2] = 24'h310311;
        rom[3] = 24'h430030;
        s_rst_n = 1'b0;
        reinit  = 1'b0;
        wr_done = 1'b0;
        wr_nack = 1'b0;
        step(3);

        // Reset values
        chk("rst_pwdn", ov5640_pwdn, 1);
        chk("rst_rstn", ov5640_rst_n, 0);
        chk("rst_req", wr_req, 0);
        chk("rst_idx", cfg_idx, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);

        // Power-up timing: pwdn 10 cycles, rst_n low 15, first request 22 after rst_n rises
        s_rst_n = 1'b1;
        step(9);
        chk("pwdn_hi", ov5640_pwdn, 1);
        step(1);
        chk("pwdn_fall", {ov5640_pwdn, ov5640_rst_n}, 2'b00);
        step(4);
        chk("rstn_lo", ov5640_rst_n, 0);
        step(1);
        chk("rstn_rise", {ov5640_pwdn, ov5640_rst_n}, 2'b01);
        step(5);
        wr_done = 1'b1;
        step(1);
        wr_done = 1'b0;
        chk("settle_ign", {wr_req, ov5640_pwdn, ov5640_rst_n, cfg_done}, 4'b0010);
        step(15);
        chk("req_early", wr_req, 0);
        step(1);
        chk("first_req", wr_req, 1);

        // Table walk with a 3 ms (12 cycle) delay entry
        serve("e0", 16'h3008, 8'h82, 1'b0);
        step(3);
        chk("dly_addr", wr_addr, 16'hFFFF);
        chk("dly_data", wr_data, 8'h03);
        chk("dly_idx", cfg_idx, 1);
        chk("dly_req", wr_req, 0);
        gap = 0;
        while (wr_req !== 1'b1 && gap < 50) begin
            step(1);
            gap++;
        end
        chk("dly_gap", gap, 15);
        serve("e2", 16'h3103, 8'h11, 1'b0);
        serve("e3", 16'h4300, 8'h30, 1'b0);
        step(1);
        chk("done_flag", cfg_done, 1);
        chk("done_idx", cfg_idx, 3);
        chk("done_err", cfg_err, 0);
        chk("done_req", wr_req, 0);

        // Stray wr_done while done
        wr_done = 1'b1;
        step(1);
        wr_done = 1'b0;
        step(2);
        chk("done_ign", {wr_req, ov5640_pwdn, ov5640_rst_n, cfg_done, cfg_idx},
            {1'b0, 1'b0, 1'b1, 1'b1, 8'd3});

        // reinit from done, then reinit colliding with wr_done in the request state
        reinit = 1'b1;
        step(1);
        reinit = 1'b0;
        chk("reinit_done", {ov5640_pwdn, ov5640_rst_n, cfg_done, cfg_idx},
            {1'b1, 1'b0, 1'b0, 8'd0});
        serve("r1_e0", 16'h3008, 8'h82, 1'b0);
        wait_req("r1_e2_req");
        chk("r1_e2_addr", wr_addr, 16'h3103);
        step(3);
        wr_done = 1'b1;
        reinit  = 1'b1;
        step(1);
        wr_done = 1'b0;
        reinit  = 1'b0;
        chk("reinit_req", {wr_req, ov5640_pwdn, ov5640_rst_n, cfg_done, cfg_idx},
            {1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        step(2);
        chk("reinit_hold", {ov5640_pwdn, cfg_idx}, {1'b1, 8'd0});

        // NACK every attempt of entry 0
        serve("n_e0", 16'h3008, 8'h82, 1'b1);
`ifdef OV5640_CFG_RETRY_EN
        for (int k = 0; k < 3; k++) begin
            serve("n_retry", 16'h3008, 8'h82, 1'b1);
        end
        chk("n_err", cfg_err, 1);
`else
        chk("n_err", cfg_err, 0);
`endif
        serve("n_e2", 16'h3103, 8'h11, 1'b0);
        serve("n_e3", 16'h4300, 8'h30, 1'b0);
        step(1);
        chk("n_done", cfg_done, 1);
`ifdef OV5640_CFG_RETRY_EN
        chk("n_err_hold", cfg_err, 1);
`else
        chk("n_err_hold", cfg_err, 0);
`endif
        reinit = 1'b1;
        step(1);
        reinit = 1'b0;
        chk("reinit_err", {cfg_err, ov5640_pwdn, cfg_done}, 3'b010);

        // Synchronous reset in the middle of a delay entry
        serve("s6_e0", 16'h3008, 8'h82, 1'b0);
        step(6);
        chk("s6_in_dly", {wr_addr, wr_req}, {16'hFFFF, 1'b0});
        s_rst_n = 1'b0;
        step(1);
        chk("s6_ctrl", {ov5640_pwdn, ov5640_rst_n, wr_req, cfg_done, cfg_err, cfg_idx},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        chk("s6_data", {wr_addr, wr_data}, 24'd0);
        s_rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
